// File: rtl/ysyx_25040101_regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for RAW/WAW hazard detection.
// Optional macro RF_BYPASS_EN forwards same-cycle write-back data and busy clears to the read ports.
module ysyx_25040101_regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD*AW-1:0]        rd_addr_i,
    output logic [NRD*XLEN-1:0]      rd_data_o,
    output logic [NRD-1:0]           rd_busy_o,
    input  logic [NWR-1:0]           wr_en_i,
    input  logic [NWR*AW-1:0]        wr_addr_i,
    input  logic [NWR*XLEN-1:0]      wr_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic                     iss_ready_o,
    output logic [(NREG-1)*XLEN-1:0] regs_flat_o
);

    // x0 has no storage; every address lookup loops over 1..NREG-1, so x0 and
    // out-of-range addresses simply never match and read as zero / not busy.
    logic [XLEN-1:0] regs [1:NREG-1];
    logic [NREG-1:1] busy;

    logic busy_hit;
    logic wr_hit;

    // An issue may proceed when its destination is idle or is being written back right now.
    always_comb begin
        busy_hit = 1'b0;
        wr_hit   = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (iss_addr_i == AW'(i) && busy[i]) begin
                busy_hit = 1'b1;
            end
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == iss_addr_i) begin
                wr_hit = 1'b1;
            end
        end
        iss_ready_o = ~busy_hit | wr_hit;
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            for (int i = 1; i < NREG; i++) begin
                if (rd_addr_i[k*AW +: AW] == AW'(i)) begin
                    rd_data_o[k*XLEN +: XLEN] = regs[i];
                    rd_busy_o[k]              = busy[i];
`ifdef RF_BYPASS_EN
                    // Ascending port order lets the highest matching write port win.
                    for (int j = 0; j < NWR; j++) begin
                        if (rst_n && wr_en_i[j] && wr_addr_i[j*AW +: AW] == AW'(i)) begin
                            rd_data_o[k*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
                            rd_busy_o[k]              = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

    // A new issue mark on the same register beats a write-back clear: the new producer owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == AW'(i)) begin
                        regs[i] <= wr_data_i[j*XLEN +: XLEN];
                        busy[i] <= 1'b0;
                    end
                end
                if (iss_en_i && iss_ready_o && iss_addr_i == AW'(i)) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 1; g < NREG; g++) begin : g_flat
        assign regs_flat_o[(g-1)*XLEN +: XLEN] = regs[g];
    end

endmodule

// File: tb/tb_ysyx_25040101_regfile_sb.sv
// Scoreboard bench for ysyx_25040101_regfile_sb: stimulus queues expectations, a negedge monitor checks them.
// Expected values follow RF_BYPASS_EN when the bench is built with that macro.
module tb_ysyx_25040101_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_READY = 2;
    localparam int K_FLAT  = 3;

    logic                     clk;
    logic                     rst_n;
    logic [NRD*AW-1:0]        rd_addr;
    logic [NRD*XLEN-1:0]      rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR*AW-1:0]        wr_addr;
    logic [NWR*XLEN-1:0]      wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     iss_ready;
    logic [(NREG-1)*XLEN-1:0] regs_flat;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    ysyx_25040101_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .iss_en_i    (iss_en),
        .iss_addr_i  (iss_addr),
        .iss_ready_o (iss_ready),
        .regs_flat_o (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic [4:0] a1, input logic [31:0] d1,
                                 input logic ien, input logic [4:0] ia);
        wr_en    = en;
        wr_addr  = {a1, a0};
        wr_data  = {d1, d0};
        iss_en   = ien;
        iss_addr = ia;
    endtask

    task automatic setRead(input logic [4:0] r0, input logic [4:0] r1);
        rd_addr = {r1, r0};
    endtask

    task automatic checkOutput(input int kind, input int idx, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation against the DUT on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.kind)
                    K_DATA:  act = rd_data[e.idx*XLEN +: XLEN];
                    K_BUSY:  act = {31'b0, rd_busy[e.idx]};
                    K_READY: act = {31'b0, iss_ready};
                    default: act = regs_flat[e.idx*XLEN +: XLEN];
                endcase
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        setRead(5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput(K_DATA, 0, 32'h0, "reset rd0");
        checkOutput(K_BUSY, 0, 32'h0, "reset busy0");
        checkOutput(K_READY, 0, 32'h1, "reset ready");
        checkOutput(K_FLAT, 4, 32'h0, "reset flat x5");
        #11 rst_n = 1'b1;

        $display("[TB] sweep reads over x0..x31");
        for (int a = 0; a < 32; a++) begin
            step();
            setRead(5'(a), 5'(31 - a));
            applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'(a));
            checkOutput(K_DATA, 0, 32'h0, "sweep rd0");
            checkOutput(K_DATA, 1, 32'h0, "sweep rd1");
            checkOutput(K_BUSY, 0, 32'h0, "sweep busy0");
            checkOutput(K_BUSY, 1, 32'h0, "sweep busy1");
            checkOutput(K_READY, 0, 32'h1, "sweep ready");
        end

        step();
        setRead(5'd1, 5'd2);
        applyStimulus(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        setRead(5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput(K_DATA, 0, 32'h0, "x0 after write");

        $display("[TB] dual write same address");
        step();
        setRead(5'd5, 5'd0);
        applyStimulus(2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 1'b0, 5'd0);
        checkOutput(K_DATA, 0, BYP ? 32'h22 : 32'h0, "x5 during dual write");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput(K_DATA, 0, 32'h22, "x5 port1 wins");
        checkOutput(K_FLAT, 4, 32'h22, "flat x5");

        $display("[TB] issue, WAW stall, write-back");
        step();
        setRead(5'd7, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7);
        checkOutput(K_READY, 0, 32'h1, "issue x7 ready");
        checkOutput(K_BUSY, 0, 32'h0, "x7 busy before edge");
        step();
        checkOutput(K_READY, 0, 32'h0, "reissue x7 stalls");
        checkOutput(K_BUSY, 0, 32'h1, "x7 busy");
        step();
        applyStimulus(2'b01, 5'd7, 32'h55, 5'd0, 32'h0, 1'b0, 5'd7);
        checkOutput(K_READY, 0, 32'h1, "ready on x7 writeback");
        checkOutput(K_DATA, 0, BYP ? 32'h55 : 32'h0, "x7 during write");
        checkOutput(K_BUSY, 0, BYP ? 32'h0 : 32'h1, "x7 busy during write");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput(K_DATA, 0, 32'h55, "x7 written");
        checkOutput(K_BUSY, 0, 32'h0, "x7 busy cleared");

        $display("[TB] issue and write-back on same register");
        step();
        setRead(5'd0, 5'd9);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
        checkOutput(K_READY, 0, 32'h1, "issue x9 ready");
        step();
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b1, 5'd9);
        checkOutput(K_READY, 0, 32'h1, "reissue x9 with writeback");
        checkOutput(K_BUSY, 1, BYP ? 32'h0 : 32'h1, "x9 busy during write");
        checkOutput(K_DATA, 1, BYP ? 32'h99 : 32'h0, "x9 during write");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9);
        checkOutput(K_BUSY, 1, 32'h1, "x9 busy after set-wins");
        checkOutput(K_DATA, 1, 32'h99, "x9 written");
        checkOutput(K_READY, 0, 32'h0, "x9 ready low");

        $display("[TB] x0 issue ignored");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0);
        checkOutput(K_READY, 0, 32'h1, "issue x0 ready");
        step();
        setRead(5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput(K_BUSY, 1, 32'h0, "x0 never busy");
        checkOutput(K_READY, 0, 32'h1, "x0 ready");

        $display("[TB] read during write-back of busy x3");
        step();
        applyStimulus(2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3);
        step();
        setRead(5'd3, 5'd0);
        applyStimulus(2'b01, 5'd3, 32'hA5A5, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput(K_DATA, 0, BYP ? 32'hA5A5 : 32'h33, "x3 during write");
        checkOutput(K_BUSY, 0, BYP ? 32'h0 : 32'h1, "x3 busy during write");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput(K_DATA, 0, 32'hA5A5, "x3 next cycle");
        checkOutput(K_BUSY, 0, 32'h0, "x3 busy next cycle");

        $display("[TB] reset pulse between edges");
        step();
        applyStimulus(2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4);
        step();
        setRead(5'd0, 5'd4);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd4);
        checkOutput(K_DATA, 1, 32'h44, "x4 before reset");
        checkOutput(K_BUSY, 1, 32'h1, "x4 busy before reset");
        checkOutput(K_READY, 0, 32'h0, "x4 ready before reset");
        step();
        rst_n = 1'b0;
        applyStimulus(2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 1'b1, 5'd4);
        checkOutput(K_DATA, 1, 32'h0, "x4 in reset");
        checkOutput(K_BUSY, 1, 32'h0, "x4 busy in reset");
        checkOutput(K_FLAT, 3, 32'h0, "flat x4 in reset");
        checkOutput(K_FLAT, 4, 32'h0, "flat x5 in reset");
        checkOutput(K_READY, 0, 32'h1, "ready in reset");
        #6;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd4);
        rst_n = 1'b1;
        step();
        checkOutput(K_DATA, 1, 32'h0, "x4 after reset");
        checkOutput(K_BUSY, 1, 32'h0, "x4 busy after reset");
        checkOutput(K_FLAT, 3, 32'h0, "flat x4 after reset");
        checkOutput(K_READY, 0, 32'h1, "ready after reset");

        for (int n = 0; n < 4 && exp_q.size() > 0; n++) begin
            step();
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
